// File: rtl/div32_unit.sv
// Multi-cycle restoring divider (quotient -> ZLo, remainder -> ZHi), one quotient bit per clock.
// Optional abort input when DIV32_ABORT_EN is defined.
module div32_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             signed_op,
`ifdef DIV32_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quo_out_q, rem_out_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] quo_q, dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q, neg_rem_q;

  logic             abort_w;
  logic [2*WIDTH:0] pair_d;
  logic [WIDTH:0]   diff_d, acc_d;
  logic [WIDTH-1:0] quo_d;
  logic             take_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

`ifdef DIV32_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // One restoring step: shift {acc,quo} left, subtract divisor when it fits.
  always_comb begin
    pair_d = {acc_q, quo_q} << 1;
    diff_d = pair_d[2*WIDTH:WIDTH] - {1'b0, dsr_q};
    take_d = pair_d[2*WIDTH:WIDTH] >= {1'b0, dsr_q};
    acc_d  = take_d ? diff_d : pair_d[2*WIDTH:WIDTH];
    quo_d  = pair_d[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, take_d};
  end

  // DONE is a one-cycle settle state; done/busy are registered so the pulse follows it.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_w && busy_q) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              dsr_q     <= magnitude(divisor, signed_op);
              quo_q     <= magnitude(dividend, signed_op);
              acc_q     <= '0;
              cnt_q     <= CW'(WIDTH);
              neg_quo_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_rem_q <= signed_op & dividend[WIDTH-1];
              busy_q    <= 1'b1;
              if (divisor == '0) begin
                quo_out_q <= '1;
                rem_out_q <= dividend;
                dbz_q     <= 1'b1;
                state_q   <= DONE;
              end else begin
                state_q <= RUN;
              end
            end
          end
          RUN: begin
            acc_q <= acc_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= FIX;
          end
          FIX: begin
            quo_out_q <= apply_sign(quo_q, neg_quo_q);
            rem_out_q <= apply_sign(acc_q[WIDTH-1:0], neg_rem_q);
            dbz_q     <= 1'b0;
            state_q   <= DONE;
          end
          DONE: begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;

endmodule

// File: tb/tb_div32_unit.sv
// Self-checking bench for div32_unit: directed corner cases plus random operands
// against an arithmetic reference model.
module tb_div32_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
`ifdef DIV32_ABORT_EN
  logic        abort;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] last_q, last_r;
  logic        last_z;

  div32_unit #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .signed_op(signed_op),
`ifdef DIV32_ABORT_EN
    .abort(abort),
`endif
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on 64-bit values, C-style truncation.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
      end else begin
        sa = longint'(a); sb = longint'(b);
      end
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
    end
  endtask

  // Called at a negedge: presents a request, returns at the negedge after E0.
  task automatic begin_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    @(negedge clock);
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input int lat, input bit busy_ok);
    logic [31:0] eq, er; logic ez;
    model(a, b, s, eq, er, ez);
    chk({tag, ".latency"}, lat, ez ? 1 : 34);
    chk({tag, ".busy_during"}, busy_ok, 1);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".dbz"}, div_by_zero, ez);
    last_q = eq; last_r = er; last_z = ez;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    int lat; bit bok;
    @(negedge clock);
    begin_op(a, b, s);
    wait_done(lat, bok);
    check_result(tag, a, b, s, lat, bok);
    @(negedge clock);
    chk({tag, ".done_one_cycle"}, done, 0);
  endtask

  initial begin
    int lat, dn;
    bit bok;
    logic [31:0] ra, rb;
    logic rs;
    clear = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
`ifdef DIV32_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.dbz", div_by_zero, 0);
    chk("reset.quotient", quotient, 0);
    chk("reset.remainder", remainder, 0);
    clear = 1'b1;

    run_op("u100_7", 32'd100, 32'd7, 1'b0);
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op("dbz55", 32'd55, 32'd0, 1'b0);
    run_op("u9_3", 32'd9, 32'd3, 1'b0);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("u_big_small", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Start pulsed at E0+10 during a busy op must be ignored.
    @(negedge clock);
    begin_op(32'd1000, 32'd10, 1'b0);
    repeat (9) @(negedge clock);
    start = 1'b1; dividend = 32'd77; divisor = 32'd0; signed_op = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(lat, bok);
    check_result("contend", 32'd1000, 32'd10, 1'b0, lat + 10, bok);

    // Back-to-back: new start in the done cycle; old outputs hold until the new FIX.
    begin_op(32'd500, 32'd3, 1'b0);
    repeat (20) @(negedge clock);
    chk("b2b.hold_q", quotient, 32'd100);
    chk("b2b.hold_r", remainder, 32'd0);
    wait_done(lat, bok);
    check_result("b2b", 32'd500, 32'd3, 1'b0, lat + 20, bok);
    @(negedge clock);
    chk("b2b.done_one_cycle", done, 0);

    // Asynchronous reset mid-operation.
    begin_op(32'd1000, 32'd7, 1'b0);
    repeat (14) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.quotient", quotient, 0);
    chk("midrst.remainder", remainder, 0);
    chk("midrst.dbz", div_by_zero, 0);
    @(negedge clock);
    clear = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) dn++;
    end
    chk("midrst.no_done", dn, 0);
    run_op("u20_6", 32'd20, 32'd6, 1'b0);

`ifdef DIV32_ABORT_EN
    @(negedge clock);
    begin_op(32'd1000, 32'd9, 1'b0);
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    dn = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) dn++;
    end
    chk("abort.no_done", dn, 0);
    chk("abort.hold_q", quotient, last_q);
    chk("abort.hold_r", remainder, last_r);
    chk("abort.hold_z", div_by_zero, last_z);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 200);
      run_op($sformatf("rand%0d", i), ra, rb, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div32_unit.md
Name: div32_unit

Overview:
- Multi-cycle 32-bit integer divider for the datapath; executes DIV.
- Takes dividend from the bus and divisor from the Y register.
- Quotient drives the D input of the ZLo register; remainder drives the D input of the ZHi register.
- The control unit pulses `start`, waits for `done`, then asserts the ZLo/ZHi enables for one cycle.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clock  in  1  rising-edge system clock
- clear  in  1  reset; asynchronous, active-low
- start  in  1  request; sampled only while busy=0
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned; captured with start
- dividend  in  WIDTH  bus value; captured with start
- divisor  in  WIDTH  Y register value; captured with start
- busy  out  1  operation in progress
- done  out  1  single-cycle completion pulse
- div_by_zero  out  1  last result came from divisor==0
- quotient  out  WIDTH  to ZLo D
- remainder  out  WIDTH  to ZHi D

Behaviour:
- Reset (clear=0, asynchronous) forces:
  - state=IDLE
  - busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0
  - internal counter/accumulators=0
- Reset mid-operation abandons the divide; no done is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - busy=0.
  - start=1 at edge E0 captures operands.
  - Capture converts operands to magnitudes when signed_op=1 and records sign of dividend and sign of quotient.
  - Capture loads count=WIDTH and sets busy=1.
  - Next state is RUN, or DONE if divisor==0.
- RUN:
  - One restoring shift-subtract step per edge: shift {rem,quo} left 1; if rem >= |divisor|, subtract and set quo LSB.
  - count decrements each step.
  - Leaves to FIX on the edge where count reaches 0, so WIDTH edges are spent in RUN.
- FIX:
  - Applies signs: quotient negated if the dividend and divisor signs differ; remainder takes the dividend's sign.
  - Loads quotient/remainder outputs, clears div_by_zero, goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle; next state IDLE.
  - Normal latency: done high following edge E0+WIDTH+2 (edge 34 for WIDTH=32).
- Divide by zero:
  - Latency 1: done high following edge E0+1.
  - Outputs: quotient=all ones, remainder=captured raw dividend, div_by_zero=1.
- Output hold: quotient, remainder and div_by_zero change only on FIX or divide-by-zero capture. Otherwise they hold, including through a following operation until its result loads.
- start handling:
  - start is accepted in the DONE cycle, because busy=0 there.
  - Back-to-back ops: new E0 = DONE edge.
  - start while busy=1 is ignored; operands on the ignored cycle are not captured.
- Signed results:
  - Truncate toward zero.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0, div_by_zero=0.
- Unsigned mode: all values are treated as 0..2^WIDTH-1.
- Arithmetic: internal remainder accumulator is WIDTH+1 bits so the compare/subtract never overflows.

Optional Feature:
- Macro: DIV32_ABORT_EN.
- Defined:
  - Adds port `abort  in  1`.
  - abort=1 at an edge while busy=1 returns to IDLE on that edge with busy=0.
  - No done pulse; quotient/remainder/div_by_zero keep their prior values.
  - abort has priority over the RUN/FIX step on the same edge and is ignored when busy=0.
  - abort and start together while busy=0: start wins.
- Undefined: no abort port; an operation always runs to DONE or reset.

Test Plan:
- Unsigned 100 / 7, signed_op=0: done pulses exactly 1 cycle, after edge E0+34. Quotient=14, remainder=2, div_by_zero=0, busy high for edges E0..E0+33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / -2: quotient=0xFFFFFFFD, remainder=1.
- Divide by zero 55 / 0: done after edge E0+1, quotient=0xFFFFFFFF, remainder=55, div_by_zero=1. Next normal op (9/3) clears the flag with its result: quotient=3, remainder=0.
- Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1: quotient=0xFFFFFFFF, remainder=0.
- Contention and back-to-back:
  - start pulsed at E0+10 with different operands during a busy op is ignored; the first result is unchanged.
  - start asserted in the DONE cycle begins a new op; old outputs hold until the new FIX.
- Reset mid-operation: clear low at E0+15 (asynchronous, between edges) immediately zeroes all outputs and busy. No done follows. A fresh 20/6 after release gives quotient=3, remainder=2.
- With DIV32_ABORT_EN: abort at E0+5 yields busy=0 on that edge, no done, prior outputs retained.
